// File: rtl/p_counter_pkg.sv
// Shared constants for the p_counter slice: default width, count
// direction encodings and bound-handling modes.
package p_counter_pkg;

   localparam int unsigned P_COUNTER_WIDTH = 8;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   localparam bit MODE_WRAP = 1'b0;
   localparam bit MODE_SAT  = 1'b1;

endpackage

// File: rtl/p_counter_if.sv
// Control/status bundle for one p_counter instance; the master side
// drives the controls, the slave side is the counter's view.
interface p_counter_if
   import p_counter_pkg::*;
#(
   parameter int unsigned WIDTH = P_COUNTER_WIDTH
);

   logic [0:WIDTH-1] count;
   logic             en;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic             tc;
   logic             wrap_pulse;

   modport master (
      output en, up, load, load_value,
      input  count, tc, wrap_pulse
   );

   modport slave (
      input  en, up, load, load_value,
      output count, tc, wrap_pulse
   );

endinterface

// File: rtl/p_counter_next.sv
// Next-count and boundary-detect logic: load > enable > hold, with
// wrap or saturate at 0 and MAX_VALUE.
module p_counter_next
   import p_counter_pkg::*;
#(
   parameter int unsigned      WIDTH     = P_COUNTER_WIDTH,
   parameter logic [WIDTH-1:0] MAX_VALUE = {WIDTH{1'b1}},
   parameter bit               SATURATE  = MODE_WRAP
) (
   input  logic [WIDTH-1:0] count,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] next_count,
   output logic             hit_bound
);

   always_comb begin
      next_count = count;
      hit_bound  = 1'b0;
      if (load) begin
         next_count = (load_value > MAX_VALUE) ? MAX_VALUE : load_value;
      end else if (en) begin
         // Bounds are compared before the add/sub so nothing overflows.
         if (up == DIR_UP) begin
            if (count < MAX_VALUE) begin
               next_count = count + 1'b1;
            end else begin
               hit_bound  = 1'b1;
               next_count = (SATURATE == MODE_SAT) ? MAX_VALUE : '0;
            end
         end else begin
            if (count != '0) begin
               next_count = count - 1'b1;
            end else begin
               hit_bound  = 1'b1;
               next_count = (SATURATE == MODE_SAT) ? '0 : MAX_VALUE;
            end
         end
      end
   end

endmodule

// File: rtl/p_counter.sv
// Parameterised up/down counter with load, programmable terminal value,
// wrap/saturate modes and an asynchronous active-low clear.
module p_counter
   import p_counter_pkg::*;
#(
   parameter int unsigned      WIDTH     = P_COUNTER_WIDTH,
   parameter logic [WIDTH-1:0] MAX_VALUE = {WIDTH{1'b1}},
   parameter bit               SATURATE  = MODE_WRAP
) (
   input  logic             clear,
   input  logic             clock,
   output logic [0:WIDTH-1] count,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             tc,
   output logic             wrap_pulse
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             wrap_pulse_q;
   logic             wrap_pulse_d;
   logic             hit_bound;

   p_counter_next #(
      .WIDTH     (WIDTH),
      .MAX_VALUE (MAX_VALUE),
      .SATURATE  (SATURATE)
   ) u_next (
      .count      (count_q),
      .en         (en),
      .up         (up),
      .load       (load),
      .load_value (load_value),
      .next_count (count_d),
      .hit_bound  (hit_bound)
   );

   always_comb begin
      wrap_pulse_d = hit_bound;
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         count_q      <= '0;
         wrap_pulse_q <= 1'b0;
      end else begin
         count_q      <= count_d;
         wrap_pulse_q <= wrap_pulse_d;
      end
   end

   // count is declared ascending, so count[0] picks up the MSB of count_q.
   assign count      = count_q;
   assign wrap_pulse = wrap_pulse_q;
   assign tc = ((up == DIR_UP) && (count_q == MAX_VALUE)) ||
               ((up == DIR_DOWN) && (count_q == '0));

endmodule

// File: tb/tb_p_counter.sv
// Directed bench for p_counter: a default 8-bit wrapping instance and a
// saturating instance with MAX_VALUE = 10, sharing clock and clear.
module tb_p_counter;

   logic clock;
   logic clear;

   int unsigned n_checks;
   int unsigned n_errors;

   p_counter_if #(.WIDTH(8)) a_if ();
   p_counter_if #(.WIDTH(8)) b_if ();

   p_counter u_dut_a (
      .clear      (clear),
      .clock      (clock),
      .count      (a_if.count),
      .en         (a_if.en),
      .up         (a_if.up),
      .load       (a_if.load),
      .load_value (a_if.load_value),
      .tc         (a_if.tc),
      .wrap_pulse (a_if.wrap_pulse)
   );

   p_counter #(
      .WIDTH     (8),
      .MAX_VALUE (8'd10),
      .SATURATE  (1'b1)
   ) u_dut_b (
      .clear      (clear),
      .clock      (clock),
      .count      (b_if.count),
      .en         (b_if.en),
      .up         (b_if.up),
      .load       (b_if.load),
      .load_value (b_if.load_value),
      .tc         (b_if.tc),
      .wrap_pulse (b_if.wrap_pulse)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and sample 1 time unit later.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_a(input string tag, input logic [31:0] cnt,
                          input logic [31:0] wp, input logic [31:0] t);
      check({tag, ".count"}, 32'(a_if.count), cnt);
      check({tag, ".wrap"}, 32'(a_if.wrap_pulse), wp);
      check({tag, ".tc"}, 32'(a_if.tc), t);
   endtask

   task automatic check_b(input string tag, input logic [31:0] cnt,
                          input logic [31:0] wp, input logic [31:0] t);
      check({tag, ".count"}, 32'(b_if.count), cnt);
      check({tag, ".wrap"}, 32'(b_if.wrap_pulse), wp);
      check({tag, ".tc"}, 32'(b_if.tc), t);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;

      clear           = 1'b0;
      a_if.en         = 1'b1;
      a_if.up         = 1'b1;
      a_if.load       = 1'b0;
      a_if.load_value = '0;
      b_if.en         = 1'b0;
      b_if.up         = 1'b1;
      b_if.load       = 1'b0;
      b_if.load_value = '0;

      // Reset state, held across an edge while clear is low.
      #2;
      check_a("rst", 0, 0, 0);
      check_b("rst_b", 0, 0, 0);
      tick();
      check_a("rst_hold", 0, 0, 0);
      clear = 1'b1;

      // Free-running up count.
      for (int i = 1; i <= 6; i++) begin
         tick();
         check_a($sformatf("up%0d", i), 32'(i), 0, 0);
      end

      // Mid-run async clear, away from any edge.
      #2 clear = 1'b0;
      #1 check_a("mid_clr", 0, 0, 0);
      #1 clear = 1'b1;
      tick(); check_a("post_clr1", 1, 0, 0);
      tick(); check_a("post_clr2", 2, 0, 0);

      // Up wrap through 0xFF.
      a_if.load = 1'b1; a_if.load_value = 8'hFE;
      tick(); check_a("ld_fe", 'hFE, 0, 0);
      a_if.load = 1'b0;
      tick(); check_a("wrap_ff", 'hFF, 0, 1);
      tick(); check_a("wrap_00", 'h00, 1, 0);
      tick(); check_a("wrap_01", 'h01, 0, 0);

      // Down count and wrap through 0.
      a_if.load = 1'b1; a_if.load_value = 8'h01; a_if.up = 1'b0;
      tick(); check_a("ld_01", 'h01, 0, 0);
      a_if.load = 1'b0;
      tick(); check_a("dn_00", 'h00, 0, 1);
      tick(); check_a("dn_ff", 'hFF, 1, 0);
      tick(); check_a("dn_fe", 'hFE, 0, 0);

      // Priority: load beats enable, hold when both low.
      a_if.up = 1'b1; a_if.en = 1'b0;
      a_if.load = 1'b1; a_if.load_value = 8'h5A;
      tick(); check_a("ld_noen", 'h5A, 0, 0);
      a_if.en = 1'b1;
      tick(); check_a("ld_en", 'h5A, 0, 0);
      a_if.load = 1'b0; a_if.en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_a($sformatf("hold%0d", i), 'h5A, 0, 0);
      end

      // Saturating instance, MAX_VALUE = 10.
      b_if.load = 1'b1; b_if.load_value = 8'd8;
      tick(); check_b("sat_ld8", 8, 0, 0);
      b_if.load = 1'b0; b_if.en = 1'b1;
      tick(); check_b("sat_9", 9, 0, 0);
      tick(); check_b("sat_10a", 10, 0, 1);
      tick(); check_b("sat_10b", 10, 1, 1);
      tick(); check_b("sat_10c", 10, 1, 1);

      // Async clear while wrap_pulse is high and no edge is near.
      #3 clear = 1'b0;
      #1;
      check_b("aclr_b", 0, 0, 0);
      check_a("aclr_a", 0, 0, 0);
      #1 clear = 1'b1;
      b_if.en = 1'b0;
      tick(); check_b("aclr_hold", 0, 0, 0);

      // Out-of-range load clamps to MAX_VALUE.
      b_if.load = 1'b1; b_if.load_value = 8'd200;
      tick(); check_b("sat_clamp", 10, 0, 1);
      b_if.load = 1'b0;
      tick(); check_b("sat_idle", 10, 0, 1);

      // Saturating down count pins at 0.
      b_if.load = 1'b1; b_if.load_value = 8'd1; b_if.up = 1'b0;
      tick(); check_b("satd_ld1", 1, 0, 0);
      b_if.load = 1'b0; b_if.en = 1'b1;
      tick(); check_b("satd_0a", 0, 0, 1);
      tick(); check_b("satd_0b", 0, 1, 1);
      b_if.en = 1'b0;
      tick(); check_b("satd_hold", 0, 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
